// File: rtl/ps2_key_ctrl_pkg.sv
// Shared scan-code constants, parser/pop state encodings and byte classifiers
// for the PS/2 key controller.
package ps2_key_ctrl_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;

  typedef enum logic [1:0] {P_BASE, P_EXT, P_BRK, P_EXTBRK} parse_state_e;
  typedef enum logic {POP_IDLE, POP_GAP} pop_state_e;

  // Keyboard housekeeping bytes that carry no key information.
  function automatic logic is_filler(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_ECHO) ||
           (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Receive-FIFO handshake between ps2_keyboard (master) and the key controller (slave).
interface ps2_key_ctrl_if;
  logic       ready;
  logic [7:0] data;
  logic       overflow;
  logic       nextdata_n;

  modport master (output ready, data, overflow, input nextdata_n);
  modport slave  (input ready, data, overflow, output nextdata_n);
endinterface

// File: rtl/ps2_key_ctrl_pop_fsm.sv
// IDLE/GAP pop sequencer: strobes nextdata_n for one cycle per byte and
// presents the popped byte with a same-cycle byte_valid pulse.
module ps2_key_ctrl_pop_fsm
  import ps2_key_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  ps2_key_ctrl_if.slave fifo,
  output logic          byte_valid_o,
  output logic [7:0]    byte_o
);

  pop_state_e state_q, state_d;
  logic       pop;

  // Reset gates the strobe so a pop can never coincide with reset.
  assign pop             = (state_q == POP_IDLE) && fifo.ready && rst_n;
  assign fifo.nextdata_n = ~pop;
  assign byte_valid_o    = pop;
  assign byte_o          = fifo.data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= POP_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      POP_IDLE: if (pop) state_d = POP_GAP;
      POP_GAP:  state_d = POP_IDLE;
      default:  state_d = POP_IDLE;
    endcase
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 key controller: parses make/break/E0 scan sequences into key events and
// tracks modifiers, caps lock, held key and press count. Macro PS2_TIMEOUT_EN adds a prefix timeout.
module ps2_key_ctrl
  import ps2_key_ctrl_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             clk,
  input  logic             clrn,
  ps2_key_ctrl_if.slave    fifo,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_release,
  output logic             key_repeat,
  output logic             shift,
  output logic             ctrl,
  output logic             caps,
  output logic             held,
  output logic [CNT_W-1:0] press_count,
  output logic             err
);

  logic       byte_valid;
  logic [7:0] byte_in;
  logic       timeout_hit;

  parse_state_e     pstate_q, pstate_d;
  logic             key_valid_q, key_valid_d, key_ext_q, key_ext_d;
  logic             key_release_q, key_release_d, key_repeat_q, key_repeat_d;
  logic [7:0]       key_code_q, key_code_d, held_code_q, held_code_d;
  logic             held_q, held_d, held_ext_q, held_ext_d;
  logic             shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic             ctrl_l_q, ctrl_l_d, ctrl_r_q, ctrl_r_d;
  logic             caps_q, caps_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ev, ev_ext, ev_rel, proto_err, same_key;

  ps2_key_ctrl_pop_fsm u_pop (
    .clk          (clk),
    .rst_n        (clrn),
    .fifo         (fifo),
    .byte_valid_o (byte_valid),
    .byte_o       (byte_in)
  );

`ifdef PS2_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counts idle cycles spent waiting for the byte that completes a prefix.
  assign to_cnt_d    = (byte_valid || pstate_q == P_BASE) ? '0 : to_cnt_q + TO_W'(1);
  assign timeout_hit = !byte_valid && (pstate_q != P_BASE) &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pstate_q      <= P_BASE;
      key_valid_q   <= 1'b0;
      key_code_q    <= '0;
      key_ext_q     <= 1'b0;
      key_release_q <= 1'b0;
      key_repeat_q  <= 1'b0;
      held_q        <= 1'b0;
      held_code_q   <= '0;
      held_ext_q    <= 1'b0;
      shift_l_q     <= 1'b0;
      shift_r_q     <= 1'b0;
      ctrl_l_q      <= 1'b0;
      ctrl_r_q      <= 1'b0;
      caps_q        <= 1'b0;
      err_q         <= 1'b0;
      cnt_q         <= '0;
    end else begin
      pstate_q      <= pstate_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      key_release_q <= key_release_d;
      key_repeat_q  <= key_repeat_d;
      held_q        <= held_d;
      held_code_q   <= held_code_d;
      held_ext_q    <= held_ext_d;
      shift_l_q     <= shift_l_d;
      shift_r_q     <= shift_r_d;
      ctrl_l_q      <= ctrl_l_d;
      ctrl_r_q      <= ctrl_r_d;
      caps_q        <= caps_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    pstate_d      = pstate_q;
    key_valid_d   = 1'b0;
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    key_release_d = key_release_q;
    key_repeat_d  = key_repeat_q;
    held_d        = held_q;
    held_code_d   = held_code_q;
    held_ext_d    = held_ext_q;
    shift_l_d     = shift_l_q;
    shift_r_d     = shift_r_q;
    ctrl_l_d      = ctrl_l_q;
    ctrl_r_d      = ctrl_r_q;
    caps_d        = caps_q;
    cnt_d         = cnt_q;
    ev            = 1'b0;
    ev_ext        = 1'b0;
    ev_rel        = 1'b0;
    proto_err     = 1'b0;
    same_key      = 1'b0;

    if (byte_valid) begin
      unique case (pstate_q)
        P_BASE: begin
          if (byte_in == SC_E0)         pstate_d = P_EXT;
          else if (byte_in == SC_F0)    pstate_d = P_BRK;
          else if (!is_filler(byte_in)) ev = 1'b1;
        end
        P_EXT: begin
          if (byte_in == SC_F0)      pstate_d = P_EXTBRK;
          else if (byte_in == SC_E0) proto_err = 1'b1;
          else begin
            ev       = 1'b1;
            ev_ext   = 1'b1;
            pstate_d = P_BASE;
          end
        end
        P_BRK, P_EXTBRK: begin
          pstate_d = P_BASE;
          if (byte_in == SC_E0 || byte_in == SC_F0) proto_err = 1'b1;
          else begin
            ev     = 1'b1;
            ev_rel = 1'b1;
            ev_ext = (pstate_q == P_EXTBRK);
          end
        end
        default: pstate_d = P_BASE;
      endcase
    end else if (timeout_hit) begin
      pstate_d = P_BASE;
    end

    // Modifiers only toggle their held bits; every other key feeds held/repeat tracking.
    if (ev) begin
      key_valid_d   = 1'b1;
      key_code_d    = byte_in;
      key_ext_d     = ev_ext;
      key_release_d = ev_rel;
      key_repeat_d  = 1'b0;
      same_key      = held_q && (held_code_q == byte_in) && (held_ext_q == ev_ext);
      if (!ev_ext && byte_in == SC_LSHIFT)      shift_l_d = !ev_rel;
      else if (!ev_ext && byte_in == SC_RSHIFT) shift_r_d = !ev_rel;
      else if (!ev_ext && byte_in == SC_CTRL)   ctrl_l_d  = !ev_rel;
      else if (ev_ext && byte_in == SC_CTRL)    ctrl_r_d  = !ev_rel;
      else if (ev_rel) begin
        if (same_key) held_d = 1'b0;
      end else if (same_key) begin
        key_repeat_d = 1'b1;
      end else begin
        held_d      = 1'b1;
        held_code_d = byte_in;
        held_ext_d  = ev_ext;
        cnt_d       = cnt_q + CNT_W'(1);
        if (!ev_ext && byte_in == SC_CAPS) caps_d = !caps_q;
      end
    end
  end

  assign err_d       = err_q | fifo.overflow | proto_err | timeout_hit;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_release = key_release_q;
  assign key_repeat  = key_repeat_q;
  assign shift       = shift_l_q | shift_r_q;
  assign ctrl        = ctrl_l_q | ctrl_r_q;
  assign caps        = caps_q;
  assign held        = held_q;
  assign press_count = cnt_q;
  assign err         = err_q;

endmodule
